// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_reg
// Purpose  : ID/EX pipeline register with stall, flush, valid tracking,
//            a saturating bubble counter and load-use hazard detection
//            against the instruction currently in ID.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              ALUSrc_i,
  input  logic              Branch_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [9:0]        funct_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   RS1data_i,
  input  logic [XLEN-1:0]   RS2data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [RA_W-1:0]   RS1addr_i,
  input  logic [RA_W-1:0]   RS2addr_i,
  input  logic [RA_W-1:0]   RDaddr_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              ALUSrc_o,
  output logic              Branch_o,
  output logic [1:0]        ALUOp_o,
  output logic [9:0]        funct_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   RS1data_o,
  output logic [XLEN-1:0]   RS2data_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [RA_W-1:0]   RS1addr_o,
  output logic [RA_W-1:0]   RS2addr_o,
  output logic [RA_W-1:0]   RDaddr_o,
  output logic              valid_o,
  output logic              hazard_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // Stage registers
  logic              r_valid;
  logic              r_regwrite, r_memtoreg, r_memread, r_memwrite, r_alusrc, r_branch;
  logic [1:0]        r_aluop;
  logic [9:0]        r_funct;
  logic [XLEN-1:0]   r_pc, r_rs1data, r_rs2data, r_imm;
  logic [RA_W-1:0]   r_rs1addr, r_rs2addr, r_rdaddr;
  logic [CNT_W-1:0]  r_bubble_cnt;

  // A bubble enters EX on a flush, or on a normal load of a non-instruction.
  logic w_bubble;
  logic w_load;
  assign w_load   = !flush_i && !stall_i;
  assign w_bubble = flush_i || (w_load && !valid_i);

  // Stage contents: reset > flush > stall > load; control squashed when ID is empty
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_branch   <= 1'b0;
      r_aluop    <= 2'b00;
      r_funct    <= '0;
      r_pc       <= '0;
      r_rs1data  <= '0;
      r_rs2data  <= '0;
      r_imm      <= '0;
      r_rs1addr  <= '0;
      r_rs2addr  <= '0;
      r_rdaddr   <= '0;
    end else if (!stall_i) begin
      r_valid    <= valid_i;
      r_regwrite <= valid_i & RegWrite_i;
      r_memtoreg <= valid_i & MemtoReg_i;
      r_memread  <= valid_i & MemRead_i;
      r_memwrite <= valid_i & MemWrite_i;
      r_alusrc   <= valid_i & ALUSrc_i;
      r_branch   <= valid_i & Branch_i;
      r_aluop    <= valid_i ? ALUOp_i : 2'b00;
      r_funct    <= funct_i;
      r_pc       <= pc_i;
      r_rs1data  <= RS1data_i;
      r_rs2data  <= RS2data_i;
      r_imm      <= imm_i;
      r_rs1addr  <= RS1addr_i;
      r_rs2addr  <= RS2addr_i;
      r_rdaddr   <= RDaddr_i;
    end
  end

  // Bubble counter: counts inserted bubbles, sticks at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Load-use hazard: a valid load in EX whose non-x0 destination is read by ID
  logic w_rd_match;
  assign w_rd_match = (r_rdaddr == RS1addr_i) || (r_rdaddr == RS2addr_i);
  assign hazard_o   = r_valid && r_memread && (r_rdaddr != '0) && w_rd_match;

  assign valid_o      = r_valid;
  assign RegWrite_o   = r_regwrite;
  assign MemtoReg_o   = r_memtoreg;
  assign MemRead_o    = r_memread;
  assign MemWrite_o   = r_memwrite;
  assign ALUSrc_o     = r_alusrc;
  assign Branch_o     = r_branch;
  assign ALUOp_o      = r_aluop;
  assign funct_o      = r_funct;
  assign pc_o         = r_pc;
  assign RS1data_o    = r_rs1data;
  assign RS2data_o    = r_rs2data;
  assign imm_o        = r_imm;
  assign RS1addr_o    = r_rs1addr;
  assign RS2addr_o    = r_rs2addr;
  assign RDaddr_o     = r_rdaddr;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe_reg
// Purpose  : Self-checking bench for id_ex_pipe_reg (4-bit bubble counter so
//            saturation is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic clk_i = 1'b0;
  logic rst_i, stall_i, flush_i, valid_i;
  logic RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i;
  logic [1:0]       ALUOp_i;
  logic [9:0]       funct_i;
  logic [XLEN-1:0]  pc_i, RS1data_i, RS2data_i, imm_i;
  logic [RA_W-1:0]  RS1addr_i, RS2addr_i, RDaddr_i;
  logic RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o;
  logic [1:0]       ALUOp_o;
  logic [9:0]       funct_o;
  logic [XLEN-1:0]  pc_o, RS1data_o, RS2data_o, imm_o;
  logic [RA_W-1:0]  RS1addr_o, RS2addr_o, RDaddr_o;
  logic             valid_o, hazard_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  id_ex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .Branch_i(Branch_i), .ALUOp_i(ALUOp_i),
    .funct_i(funct_i), .pc_i(pc_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
    .imm_i(imm_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o), .ALUOp_o(ALUOp_o),
    .funct_o(funct_o), .pc_o(pc_o), .RS1data_o(RS1data_o), .RS2data_o(RS2data_o),
    .imm_o(imm_o), .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .valid_o(valid_o), .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Full observable stage state, packed for one-shot comparison
  typedef struct packed {
    logic             valid;
    logic             rw, m2r, mr, mw, as, br;
    logic [1:0]       aluop;
    logic [9:0]       funct;
    logic [XLEN-1:0]  pc, d1, d2, imm;
    logic [RA_W-1:0]  a1, a2, rd;
    logic [CNT_W-1:0] cnt;
  } st_t;

  // One stimulus record; chk selects whether the hand-written expectations apply
  typedef struct {
    logic             rst, stall, flush, valid;
    logic             rw, m2r, mr, mw, as, br;
    logic [1:0]       aluop;
    logic [9:0]       funct;
    logic [XLEN-1:0]  pc, d1, d2, imm;
    logic [RA_W-1:0]  a1, a2, rd;
    bit               chk;
    logic             ev, eh;
    logic [CNT_W-1:0] ec;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  st_t  ms;            // reference model state
  st_t  exp_q[$];      // scoreboard: expected stage state
  logic hz_q[$];       // scoreboard: expected hazard

  function automatic vec_t nv();
    vec_t v;
    v = '{rst:0, stall:0, flush:0, valid:1, rw:0, m2r:0, mr:0, mw:0, as:0, br:0,
          aluop:2'b00, funct:'0, pc:'0, d1:'0, d2:'0, imm:'0, a1:'0, a2:'0, rd:'0,
          chk:0, ev:0, eh:0, ec:'0};
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c);
    int n;
    n = int'(c) + 1;
    if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
    return n[CNT_W-1:0];
  endfunction

  // Reference behaviour of one clock edge
  function automatic st_t model_step(st_t s, vec_t v);
    st_t n;
    n = s;
    if (v.rst) begin
      n = '0;
    end else if (v.flush) begin
      n = '0;
      n.cnt = sat_inc(s.cnt);
    end else if (!v.stall) begin
      n.valid = v.valid;
      {n.rw, n.m2r, n.mr, n.mw, n.as, n.br} = v.valid ? {v.rw, v.m2r, v.mr, v.mw, v.as, v.br} : 6'b0;
      n.aluop = v.valid ? v.aluop : 2'b00;
      n.funct = v.funct;  n.pc = v.pc;   n.d1 = v.d1;  n.d2 = v.d2;  n.imm = v.imm;
      n.a1 = v.a1;        n.a2 = v.a2;   n.rd = v.rd;
      if (!v.valid) n.cnt = sat_inc(s.cnt);
    end
    return n;
  endfunction

  task automatic drive(vec_t v);
    rst_i = v.rst;  stall_i = v.stall;  flush_i = v.flush;  valid_i = v.valid;
    RegWrite_i = v.rw;  MemtoReg_i = v.m2r;  MemRead_i = v.mr;  MemWrite_i = v.mw;
    ALUSrc_i = v.as;    Branch_i = v.br;     ALUOp_i = v.aluop; funct_i = v.funct;
    pc_i = v.pc;  RS1data_i = v.d1;  RS2data_i = v.d2;  imm_i = v.imm;
    RS1addr_i = v.a1;  RS2addr_i = v.a2;  RDaddr_i = v.rd;
  endtask

  // Drive one vector, push model expectation, clock, then pop and compare
  task automatic apply(string name, vec_t v);
    st_t  got, e;
    logic eh;
    drive(v);
    ms = model_step(ms, v);
    exp_q.push_back(ms);
    hz_q.push_back(ms.valid && ms.mr && (ms.rd != '0) && (ms.rd == v.a1 || ms.rd == v.a2));
    @(posedge clk_i);
    #1;
    e  = exp_q.pop_front();
    eh = hz_q.pop_front();
    got = {valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o,
           ALUOp_o, funct_o, pc_o, RS1data_o, RS2data_o, imm_o,
           RS1addr_o, RS2addr_o, RDaddr_o, bubble_cnt_o};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s state: got %h expected %h", name, got, e);
    end
    checks++;
    if (hazard_o !== eh) begin
      errors++;
      $display("FAIL %s hazard: got %b expected %b", name, hazard_o, eh);
    end
    checks++;
    if (!valid_o && (RegWrite_o || MemRead_o || MemWrite_o || Branch_o)) begin
      errors++;
      $display("FAIL %s invariant: valid_o=0 with ctrl rw=%b mr=%b mw=%b br=%b expected 0",
               name, RegWrite_o, MemRead_o, MemWrite_o, Branch_o);
    end
    if (v.chk) begin
      checks++;
      if ({valid_o, hazard_o, bubble_cnt_o} !== {v.ev, v.eh, v.ec}) begin
        errors++;
        $display("FAIL %s table: got valid=%b hazard=%b cnt=%h expected valid=%b hazard=%b cnt=%h",
                 name, valid_o, hazard_o, bubble_cnt_o, v.ev, v.eh, v.ec);
      end
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    ms = '0;
    // reset held with every input high
    v = nv(); v.rst = 1; v.stall = 1; v.flush = 1; v.valid = 1;
    {v.rw, v.m2r, v.mr, v.mw, v.as, v.br} = 6'h3F; v.aluop = 2'b11; v.funct = '1;
    v.pc = '1; v.d1 = '1; v.d2 = '1; v.imm = '1; v.a1 = '1; v.a2 = '1; v.rd = '1;
    v.chk = 1; v.ev = 0; v.eh = 0; v.ec = 4'h0;
    tbl.push_back(v); tbl.push_back(v);
    // lw x5, 4(x5): hazard against its own rs1 still in ID
    v = nv(); v.rw = 1; v.m2r = 1; v.mr = 1; v.as = 1; v.rd = 5; v.a1 = 5; v.imm = 4;
    v.d1 = 32'd100; v.pc = 32'h10; v.funct = 10'h002;
    v.chk = 1; v.ev = 1; v.eh = 1; v.ec = 4'h0;
    tbl.push_back(v);
    // lw to x0 never hazards
    v.rd = 0; v.a1 = 0; v.pc = 32'h14; v.eh = 0;
    tbl.push_back(v);
    // R-type then three stalled cycles with unrelated inputs
    v = nv(); v.rw = 1; v.aluop = 2'b10; v.d1 = 32'h1234; v.d2 = 32'h55; v.funct = 10'h100;
    v.a1 = 1; v.a2 = 2; v.rd = 3; v.pc = 32'h18;
    v.chk = 1; v.ev = 1; v.eh = 0; v.ec = 4'h0;
    tbl.push_back(v);
    for (int i = 0; i < 3; i++) begin
      v = nv(); v.stall = 1; v.mr = 1; v.mw = 1; v.br = 1; v.aluop = 2'b01;
      v.rd = 5'(9 + i); v.a1 = 3; v.a2 = 5'(20 + i); v.d1 = 32'hCAFE0000 + i;
      v.pc = 32'h100 + 4 * i; v.imm = 32'hFFFF_FFF0;
      v.chk = 1; v.ev = 1; v.eh = 0; v.ec = 4'h0;
      tbl.push_back(v);
    end
    // beq with stall and flush together: flush wins
    v = nv(); v.stall = 1; v.flush = 1; v.br = 1; v.aluop = 2'b01; v.a1 = 4; v.a2 = 6;
    v.d1 = 32'h77; v.pc = 32'h1C;
    v.chk = 1; v.ev = 0; v.eh = 0; v.ec = 4'h1;
    tbl.push_back(v);
    // non-instruction in ID: ctrl squashed, data still loaded
    v = nv(); v.valid = 0; v.rw = 1; v.mw = 1; v.d1 = 32'hDEAD; v.rd = 8; v.pc = 32'h20;
    v.chk = 1; v.ev = 0; v.eh = 0; v.ec = 4'h2;
    tbl.push_back(v);
    // load to x7, then hazard through each source port while stalled
    v = nv(); v.mr = 1; v.m2r = 1; v.rw = 1; v.as = 1; v.rd = 7; v.a1 = 1; v.a2 = 2;
    v.pc = 32'h24; v.chk = 1; v.ev = 1; v.eh = 0; v.ec = 4'h2;
    tbl.push_back(v);
    v = nv(); v.stall = 1; v.a1 = 1; v.a2 = 7; v.chk = 1; v.ev = 1; v.eh = 1; v.ec = 4'h2;
    tbl.push_back(v);
    v = nv(); v.stall = 1; v.valid = 0; v.a1 = 7; v.a2 = 0; v.chk = 1; v.ev = 1; v.eh = 1; v.ec = 4'h2;
    tbl.push_back(v);
    v = nv(); v.flush = 1; v.a1 = 7; v.chk = 1; v.ev = 0; v.eh = 0; v.ec = 4'h3;
    tbl.push_back(v);

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Counter saturation: 15 flushes then 3 more, must stick at all-ones
    for (int i = 0; i < 15; i++) begin
      v = nv(); v.flush = 1; v.d1 = 32'(i);
      apply($sformatf("sat_fill%0d", i), v);
    end
    for (int i = 0; i < 3; i++) begin
      v = nv(); v.flush = 1; v.chk = 1; v.ev = 0; v.eh = 0; v.ec = 4'hF;
      apply($sformatf("sat_hold%0d", i), v);
    end
    v = nv(); v.valid = 0; v.chk = 1; v.ev = 0; v.eh = 0; v.ec = 4'hF;
    apply("sat_novalid", v);

    // Fill the stage, stall, then reset during the stall
    v = nv(); v.rw = 1; v.mr = 1; v.rd = 5; v.a1 = 5; v.d1 = 32'hA5A5; v.pc = 32'h40;
    v.chk = 1; v.ev = 1; v.eh = 1; v.ec = 4'hF;
    apply("pre_rst_load", v);
    v = nv(); v.stall = 1; v.a2 = 5; v.chk = 1; v.ev = 1; v.eh = 1; v.ec = 4'hF;
    apply("pre_rst_stall", v);
    v = nv(); v.rst = 1; v.stall = 1; v.a1 = 5; v.a2 = 5; v.rw = 1; v.mr = 1; v.rd = 5;
    v.chk = 1; v.ev = 0; v.eh = 0; v.ec = 4'h0;
    apply("rst_mid_stall", v);
    checks++;
    if ({RegWrite_o, MemRead_o, pc_o, RS1data_o, RDaddr_o} !== '0) begin
      errors++;
      $display("FAIL rst_fields: got rw=%b mr=%b pc=%h d1=%h rd=%0d expected all 0",
               RegWrite_o, MemRead_o, pc_o, RS1data_o, RDaddr_o);
    end
    // counting restarts from zero after reset
    v = nv(); v.valid = 0; v.chk = 1; v.ev = 0; v.eh = 0; v.ec = 4'h1;
    apply("post_rst_bubble", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
